can_bit_destuff: RTL and testbench

// - Receive-path destuffer between the bit sampler and the stuff-error monitor.
// - Tracks runs of identical sampled bits and marks the bit after RUN_LEN equal bits as a stuff bit.
// - Publishes the expected stuff value, removes stuff bits from the data stream and flags violations.

---
 rtl/can_pkg.sv | 16 +
 rtl/can_bit_destuff_if.sv | 43 ++++
 rtl/can_run_counter.sv | 45 ++++
 rtl/can_bit_destuff.sv | 112 +++++++++++
 tb/tb_can_bit_destuff.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/can_pkg.sv
// Shared types and constants for the CAN receive-path bit destuffer.
// Used by can_bit_destuff, can_run_counter and can_bit_destuff_if.
package can_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        STUFF = 2'd2,
        ERROR = 2'd3
    } state_e;

    localparam int   CAN_RUN_LEN   = 5;
    localparam int   CAN_CNT_W     = 4;
    localparam logic CAN_RECESSIVE = 1'b1;

endpackage

// File: rtl/can_bit_destuff_if.sv
// Bit-stream bundle between the bit sampler (master) and the destuffer (slave).
// Carries the sampled-bit strobe in and the destuffed stream and status out.
interface can_bit_destuff_if
    import can_pkg::*;
#(
    parameter int CNT_W = CAN_CNT_W
);

    logic             i_Enable;
    logic             i_Bit_Valid;
    logic             i_Data;
    logic             o_Data;
    logic             o_Data_Valid;
    logic             o_Stuff_Bit;
    logic             o_Temp_Stuff;
    logic             o_Stuff_Error;
    logic [CNT_W-1:0] o_Run_Count;

    modport master (
        output i_Enable,
        output i_Bit_Valid,
        output i_Data,
        input  o_Data,
        input  o_Data_Valid,
        input  o_Stuff_Bit,
        input  o_Temp_Stuff,
        input  o_Stuff_Error,
        input  o_Run_Count
    );

    modport slave (
        input  i_Enable,
        input  i_Bit_Valid,
        input  i_Data,
        output o_Data,
        output o_Data_Valid,
        output o_Stuff_Bit,
        output o_Temp_Stuff,
        output o_Stuff_Error,
        output o_Run_Count
    );

endinterface

// File: rtl/can_run_counter.sv
// Saturating counter of consecutive equal bits for the CAN destuffer.
// at_limit flags that the bit currently offered completes a full run.
module can_run_counter
    import can_pkg::*;
#(
    parameter int RUN_LEN = CAN_RUN_LEN,
    parameter int CNT_W   = CAN_CNT_W
) (
    input  logic             i_Clock,
    input  logic             i_Reset,
    input  logic             data,
    input  logic             valid,
    input  logic             clear,
    output logic [CNT_W-1:0] run,
    output logic             last,
    output logic             at_limit
);

    localparam logic [CNT_W-1:0] LIMIT    = CNT_W'(RUN_LEN);
    localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(RUN_LEN - 1);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    // Combinational look-ahead: this bit extends the run up to RUN_LEN.
    always_comb begin
        at_limit = (data == last) && (run == LIMIT_M1);
    end

    // Count equal bits, restart on a change; cleared runs resume from recessive.
    always_ff @(posedge i_Clock) begin
        if (i_Reset || clear) begin
            run  <= '0;
            last <= CAN_RECESSIVE;
        end else if (valid) begin
            if (data == last) begin
                if (run != LIMIT) begin
                    run <= run + ONE;
                end
            end else begin
                run  <= ONE;
                last <= data;
            end
        end
    end

endmodule

// File: rtl/can_bit_destuff.sv
// CAN receive-path bit destuffer: removes stuff bits and flags violations.
// Optional macro STUFF_ERR_STICKY_EN holds o_Stuff_Error until reset/disable.
module can_bit_destuff
    import can_pkg::*;
#(
    parameter int RUN_LEN = CAN_RUN_LEN,
    parameter int CNT_W   = CAN_CNT_W
) (
    input  logic             i_Clock,
    input  logic             i_Reset,
    can_bit_destuff_if.slave bus
);

    state_e           state;
    logic [CNT_W-1:0] run;
    logic             last;
    logic             at_limit;
    logic             cnt_valid;
    logic             cnt_clear;

    logic             data_q;
    logic             data_valid_q;
    logic             stuff_bit_q;
    logic             temp_stuff_q;
    logic             stuff_error_q;

    // Counter advances on every bit the FSM accepts; disable restarts the run.
    always_comb begin
        cnt_clear = !bus.i_Enable;
        cnt_valid = bus.i_Enable && bus.i_Bit_Valid
                 && (state != ERROR);
    end

    can_run_counter #(
        .RUN_LEN (RUN_LEN),
        .CNT_W   (CNT_W)
    ) u_run_counter (
        .i_Clock  (i_Clock),
        .i_Reset  (i_Reset),
        .data     (bus.i_Data),
        .valid    (cnt_valid),
        .clear    (cnt_clear),
        .run      (run),
        .last     (last),
        .at_limit (at_limit)
    );

    // Destuff FSM and registered output strobes.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state         <= IDLE;
            data_q        <= 1'b0;
            data_valid_q  <= 1'b0;
            stuff_bit_q   <= 1'b0;
            temp_stuff_q  <= 1'b0;
            stuff_error_q <= 1'b0;
        end else begin
            data_valid_q <= 1'b0;
            stuff_bit_q  <= 1'b0;
`ifdef STUFF_ERR_STICKY_EN
            if (!bus.i_Enable) begin
                stuff_error_q <= 1'b0;
            end
`else
            stuff_error_q <= 1'b0;
`endif
            if (!bus.i_Enable) begin
                state <= IDLE;
            end else begin
                unique case (state)
                    IDLE, COUNT: begin
                        state <= COUNT;
                        if (bus.i_Bit_Valid) begin
                            data_q       <= bus.i_Data;
                            data_valid_q <= 1'b1;
                            temp_stuff_q <= bus.i_Data;
                            if (at_limit) begin
                                state <= STUFF;
                            end
                        end
                    end
                    STUFF: begin
                        if (bus.i_Bit_Valid) begin
                            stuff_bit_q  <= 1'b1;
                            temp_stuff_q <= ~last;
                            if (bus.i_Data != last) begin
                                state <= COUNT;
                            end else begin
                                stuff_error_q <= 1'b1;
                                state         <= ERROR;
                            end
                        end
                    end
                    ERROR: begin
                        state <= ERROR;
                    end
                endcase
            end
        end
    end

    // Drive the bundle from the output registers.
    always_comb begin
        bus.o_Data        = data_q;
        bus.o_Data_Valid  = data_valid_q;
        bus.o_Stuff_Bit   = stuff_bit_q;
        bus.o_Temp_Stuff  = temp_stuff_q;
        bus.o_Stuff_Error = stuff_error_q;
        bus.o_Run_Count   = run;
    end

endmodule

// File: tb/tb_can_bit_destuff.sv
// Directed bench for can_bit_destuff with a history-based reference model.
// Model derives stuff positions from the trailing run of the raw bit history.
module tb_can_bit_destuff;

    localparam int RUN_LEN = 5;
    localparam int CNT_W   = 4;
`ifdef STUFF_ERR_STICKY_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    bit   chk_on = 1'b0;

    always #5 clk = ~clk;

    can_bit_destuff_if #(.CNT_W(CNT_W)) bus ();

    can_bit_destuff #(
        .RUN_LEN (RUN_LEN),
        .CNT_W   (CNT_W)
    ) dut (
        .i_Clock (clk),
        .i_Reset (rst),
        .bus     (bus)
    );

    // ---------------- reference model ----------------
    bit   hist[$];
    bit   m_err;
    logic e_data, e_dv, e_sb, e_temp, e_se;
    logic [CNT_W-1:0] e_run;
    int   m_r;
    bit   m_prev;

    function automatic int trailing();
        int n = 0;
        if (hist.size() == 0) return 0;
        for (int i = hist.size() - 1; i >= 0; i--) begin
            if (hist[i] == hist[hist.size()-1]) n++;
            else break;
        end
        return n;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            hist.delete();
            m_err = 1'b0;
            e_data = 0; e_dv = 0; e_sb = 0;
            e_temp = 0; e_se = 0; e_run = '0;
        end else begin
            e_dv = 0;
            e_sb = 0;
            if (!STICKY) e_se = 0;
            if (!bus.i_Enable) begin
                hist.delete();
                m_err = 1'b0;
                e_run = '0;
                e_se  = 0;
            end else if (bus.i_Bit_Valid && !m_err) begin
                m_r    = trailing();
                m_prev = (hist.size() == 0) ? 1'b1 : hist[hist.size()-1];
                if (m_r == RUN_LEN) begin
                    e_sb   = 1;
                    e_temp = ~m_prev;
                    if (bus.i_Data == m_prev) begin
                        e_se  = 1;
                        m_err = 1'b1;
                    end
                end else begin
                    e_dv   = 1;
                    e_data = bus.i_Data;
                    e_temp = bus.i_Data;
                end
                hist.push_back(bus.i_Data);
                m_r   = trailing();
                e_run = CNT_W'((m_r > RUN_LEN) ? RUN_LEN : m_r);
            end
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [7:0] act,
                       input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    int cnt_dv = 0;
    int cnt_sb = 0;
    int cnt_se = 0;

    always @(negedge clk) begin
        if (chk_on) begin
            chk("data",   8'(bus.o_Data),        8'(e_data));
            chk("dvalid", 8'(bus.o_Data_Valid),  8'(e_dv));
            chk("stuff",  8'(bus.o_Stuff_Bit),   8'(e_sb));
            chk("temp",   8'(bus.o_Temp_Stuff),  8'(e_temp));
            chk("serr",   8'(bus.o_Stuff_Error), 8'(e_se));
            chk("run",    8'(bus.o_Run_Count),   8'(e_run));
            if (bus.o_Data_Valid) cnt_dv++;
            if (bus.o_Stuff_Bit)  cnt_sb++;
            if (bus.o_Stuff_Error) cnt_se++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input bit r, input bit e, input bit v, input bit d);
        rst             = r;
        bus.i_Enable    = e;
        bus.i_Bit_Valid = v;
        bus.i_Data      = d;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input bit d);
        drive(0, 1, 1, d);
    endtask

    task automatic off(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0);
    endtask

    int b_dv, b_sb, b_se;

    initial begin
        bus.i_Enable    = 1'b0;
        bus.i_Bit_Valid = 1'b0;
        bus.i_Data      = 1'b0;
        drive(1, 0, 0, 0);
        chk_on = 1'b1;
        drive(1, 1, 1, 1);
        chk("rst_data", 8'(bus.o_Data),        8'h0);
        chk("rst_dv",   8'(bus.o_Data_Valid),  8'h0);
        chk("rst_sb",   8'(bus.o_Stuff_Bit),   8'h0);
        chk("rst_temp", 8'(bus.o_Temp_Stuff),  8'h0);
        chk("rst_serr", 8'(bus.o_Stuff_Error), 8'h0);
        chk("rst_run",  8'(bus.o_Run_Count),   8'h0);
        off(2);

        // 1: stuffed frame
        b_dv = cnt_dv; b_se = cnt_se;
        drive(0, 1, 0, 0);
        for (int i = 0; i < 5; i++) send(0);
        chk("t1_run5", 8'(bus.o_Run_Count), 8'd5);
        send(1);
        chk("t1_sb",   8'(bus.o_Stuff_Bit),  8'h1);
        chk("t1_temp", 8'(bus.o_Temp_Stuff), 8'h1);
        chk("t1_dv",   8'(bus.o_Data_Valid), 8'h0);
        send(0);
        drive(0, 1, 0, 0);
        send(1);
        chk("t1_d1", 8'(bus.o_Data), 8'h1);
        off(1);
        chk("t1_ndv", 8'(cnt_dv - b_dv), 8'd7);
        chk("t1_nse", 8'(cnt_se - b_se), 8'd0);
        off(1);

        // 2: violation
        b_dv = cnt_dv;
        drive(0, 1, 0, 0);
        for (int i = 0; i < 5; i++) send(0);
        send(0);
        chk("t2_serr", 8'(bus.o_Stuff_Error), 8'h1);
        chk("t2_sb",   8'(bus.o_Stuff_Bit),   8'h1);
        send(1); send(0); send(1);
        chk("t2_hold", 8'(bus.o_Stuff_Error), 8'(STICKY));
        chk("t2_ndv",  8'(cnt_dv - b_dv), 8'd5);
        off(1);
        chk("t2_clr", 8'(bus.o_Stuff_Error), 8'h0);
        off(1);

        // 3: run reset by a change of level
        send(1); send(1); send(1); send(1);
        for (int i = 0; i < 5; i++) send(0);
        send(1);
        chk("t3_sb",   8'(bus.o_Stuff_Bit),   8'h1);
        chk("t3_serr", 8'(bus.o_Stuff_Error), 8'h0);
        chk("t3_run",  8'(bus.o_Run_Count),   8'd1);
        off(2);

        // 4: recessive start
        drive(0, 1, 0, 0);
        for (int i = 0; i < 5; i++) send(1);
        send(0);
        chk("t4_sb",   8'(bus.o_Stuff_Bit),  8'h1);
        chk("t4_temp", 8'(bus.o_Temp_Stuff), 8'h0);
        chk("t4_run",  8'(bus.o_Run_Count),  8'd1);
        off(2);

        // 5: enable drop with a bit, then reset inside STUFF
        send(0); send(1);
        drive(0, 0, 1, 0);
        chk("t5_dv",  8'(bus.o_Data_Valid), 8'h0);
        chk("t5_sb",  8'(bus.o_Stuff_Bit),  8'h0);
        chk("t5_run", 8'(bus.o_Run_Count),  8'd0);
        for (int i = 0; i < 5; i++) send(0);
        drive(1, 1, 1, 0);
        chk("t5r_data", 8'(bus.o_Data),        8'h0);
        chk("t5r_dv",   8'(bus.o_Data_Valid),  8'h0);
        chk("t5r_sb",   8'(bus.o_Stuff_Bit),   8'h0);
        chk("t5r_serr", 8'(bus.o_Stuff_Error), 8'h0);
        chk("t5r_run",  8'(bus.o_Run_Count),   8'd0);
        drive(0, 1, 0, 0);
        send(0);
        chk("t5_idle_dv", 8'(bus.o_Data_Valid), 8'h1);
        off(2);

        // 6: back-to-back alternating bits
        b_dv = cnt_dv; b_sb = cnt_sb;
        for (int i = 0; i < 12; i++) send(1'(i & 1));
        off(1);
        chk("t6_ndv", 8'(cnt_dv - b_dv), 8'd12);
        chk("t6_nsb", 8'(cnt_sb - b_sb), 8'd0);
        off(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
